// File: rtl/rs_entry_select.sv
// rs_entry_select: reservation-station entry array with CDB wakeup
// and oldest-ready select, one instance per RS type.
module rs_entry_select #(
  parameter  int NUM_RS_ENTRIES = 8,
  parameter  int TAG_W          = 6,
  parameter  int PAYLOAD_W      = 64,
  localparam int IDX_W          = $clog2(NUM_RS_ENTRIES),
  localparam int OCC_W          = IDX_W + 1,
  localparam int N              = NUM_RS_ENTRIES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 disp_valid_0,
  input  logic                 disp_valid_1,
  input  logic [IDX_W-1:0]     disp_idx_0,
  input  logic [IDX_W-1:0]     disp_idx_1,
  input  logic [TAG_W-1:0]     disp_src1_tag_0,
  input  logic [TAG_W-1:0]     disp_src2_tag_0,
  input  logic [TAG_W-1:0]     disp_src1_tag_1,
  input  logic [TAG_W-1:0]     disp_src2_tag_1,
  input  logic                 disp_src1_rdy_0,
  input  logic                 disp_src2_rdy_0,
  input  logic                 disp_src1_rdy_1,
  input  logic                 disp_src2_rdy_1,
  input  logic [PAYLOAD_W-1:0] disp_payload_0,
  input  logic [PAYLOAD_W-1:0] disp_payload_1,
  input  logic                 cdb_valid_0,
  input  logic                 cdb_valid_1,
  input  logic [TAG_W-1:0]     cdb_tag_0,
  input  logic [TAG_W-1:0]     cdb_tag_1,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [IDX_W-1:0]     issue_idx,
  output logic [TAG_W-1:0]     issue_src1_tag,
  output logic [TAG_W-1:0]     issue_src2_tag,
  output logic [PAYLOAD_W-1:0] issue_payload,
  output logic                 issue_free_valid,
  output logic [IDX_W:0]       issue_free,
  output logic [OCC_W-1:0]     occupancy
);

  logic [N-1:0]         valid_q, valid_d;
  logic [N-1:0]         s1_rdy_q, s1_rdy_d;
  logic [N-1:0]         s2_rdy_q, s2_rdy_d;
  logic [TAG_W-1:0]     s1_tag_q [N];
  logic [TAG_W-1:0]     s1_tag_d [N];
  logic [TAG_W-1:0]     s2_tag_q [N];
  logic [TAG_W-1:0]     s2_tag_d [N];
  logic [PAYLOAD_W-1:0] payload_q [N];
  logic [PAYLOAD_W-1:0] payload_d [N];
  logic [N-1:0]         older_q [N];
  logic [N-1:0]         older_d [N];
  logic [OCC_W-1:0]     occ_q, occ_d;

  logic [N-1:0] ready;
  logic [N-1:0] grant;
  logic         fire;

  function automatic logic cdb_hit(input logic [TAG_W-1:0] t);
    return (cdb_valid_0 && cdb_tag_0 == t) ||
           (cdb_valid_1 && cdb_tag_1 == t);
  endfunction

  assign ready = valid_q & s1_rdy_q & s2_rdy_q;

  // Entry i wins unless some ready entry is older than it.
  always_comb begin
    logic blocked;
    blocked = 1'b0;
    grant   = '0;
    for (int i = 0; i < N; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < N; j++) begin
        blocked = blocked | (ready[j] & older_q[j][i]);
      end
      grant[i] = ready[i] & ~blocked;
    end
  end

  always_comb begin
    issue_valid    = |grant;
    issue_idx      = '0;
    issue_src1_tag = '0;
    issue_src2_tag = '0;
    issue_payload  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        issue_idx      = issue_idx | IDX_W'(i);
        issue_src1_tag = issue_src1_tag | s1_tag_q[i];
        issue_src2_tag = issue_src2_tag | s2_tag_q[i];
        issue_payload  = issue_payload | payload_q[i];
      end
    end
  end

  assign fire             = issue_valid & issue_ready;
  assign issue_free_valid = fire;
  assign issue_free       = {1'b0, issue_idx};
  assign occupancy        = occ_q;

  always_comb begin
    logic [N-1:0] live;
    valid_d   = valid_q;
    s1_rdy_d  = s1_rdy_q;
    s2_rdy_d  = s2_rdy_q;
    s1_tag_d  = s1_tag_q;
    s2_tag_d  = s2_tag_q;
    payload_d = payload_q;
    older_d   = older_q;
    occ_d     = occ_q;
    live      = valid_q;
    if (flush) begin
      valid_d  = '0;
      s1_rdy_d = '0;
      s2_rdy_d = '0;
      older_d  = '{default: '0};
      occ_d    = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (valid_q[i]) begin
          if (cdb_hit(s1_tag_q[i])) s1_rdy_d[i] = 1'b1;
          if (cdb_hit(s2_tag_q[i])) s2_rdy_d[i] = 1'b1;
        end
      end
      if (fire) begin
        valid_d[issue_idx] = 1'b0;
        live[issue_idx]    = 1'b0;
        older_d[issue_idx] = '0;
        for (int j = 0; j < N; j++) older_d[j][issue_idx] = 1'b0;
      end
      if (disp_valid_0) begin
        valid_d[disp_idx_0]   = 1'b1;
        s1_tag_d[disp_idx_0]  = disp_src1_tag_0;
        s2_tag_d[disp_idx_0]  = disp_src2_tag_0;
        s1_rdy_d[disp_idx_0]  = disp_src1_rdy_0 | cdb_hit(disp_src1_tag_0);
        s2_rdy_d[disp_idx_0]  = disp_src2_rdy_0 | cdb_hit(disp_src2_tag_0);
        payload_d[disp_idx_0] = disp_payload_0;
        for (int j = 0; j < N; j++) older_d[j][disp_idx_0] = live[j];
        older_d[disp_idx_0] = '0;
      end
      // Port 1 is younger than port 0 when both write this cycle.
      if (disp_valid_1) begin
        valid_d[disp_idx_1]   = 1'b1;
        s1_tag_d[disp_idx_1]  = disp_src1_tag_1;
        s2_tag_d[disp_idx_1]  = disp_src2_tag_1;
        s1_rdy_d[disp_idx_1]  = disp_src1_rdy_1 | cdb_hit(disp_src1_tag_1);
        s2_rdy_d[disp_idx_1]  = disp_src2_rdy_1 | cdb_hit(disp_src2_tag_1);
        payload_d[disp_idx_1] = disp_payload_1;
        for (int j = 0; j < N; j++) begin
          older_d[j][disp_idx_1] = live[j] |
            (disp_valid_0 && IDX_W'(j) == disp_idx_0);
        end
        older_d[disp_idx_1] = '0;
      end
      occ_d = occ_q + OCC_W'(disp_valid_0) + OCC_W'(disp_valid_1)
            - OCC_W'(fire);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      s1_rdy_q <= '0;
      s2_rdy_q <= '0;
      older_q  <= '{default: '0};
      occ_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      s1_rdy_q <= s1_rdy_d;
      s2_rdy_q <= s2_rdy_d;
      older_q  <= older_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_tag_q  <= s1_tag_d;
    s2_tag_q  <= s2_tag_d;
    payload_q <= payload_d;
  end

  a_disp0_busy: assert property (@(posedge clk) disable iff (rst || flush)
    disp_valid_0 |-> !valid_q[disp_idx_0]);
  a_disp1_busy: assert property (@(posedge clk) disable iff (rst || flush)
    disp_valid_1 |-> !valid_q[disp_idx_1]);
  a_disp_same: assert property (@(posedge clk) disable iff (rst || flush)
    !(disp_valid_0 && disp_valid_1 && disp_idx_0 == disp_idx_1));
  a_grant_1h: assert property (@(posedge clk) disable iff (rst)
    $onehot0(grant));

endmodule

// File: tb/tb_rs_entry_select.sv
// tb_rs_entry_select: directed stimulus with a queue scoreboard;
// a negedge monitor checks every accepted issue against the queue.
module tb_rs_entry_select;
  localparam int IW = 3;
  localparam int TW = 6;
  localparam int PW = 64;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          disp_valid_0, disp_valid_1;
  logic [IW-1:0] disp_idx_0, disp_idx_1;
  logic [TW-1:0] disp_src1_tag_0, disp_src2_tag_0;
  logic [TW-1:0] disp_src1_tag_1, disp_src2_tag_1;
  logic          disp_src1_rdy_0, disp_src2_rdy_0;
  logic          disp_src1_rdy_1, disp_src2_rdy_1;
  logic [PW-1:0] disp_payload_0, disp_payload_1;
  logic          cdb_valid_0, cdb_valid_1;
  logic [TW-1:0] cdb_tag_0, cdb_tag_1;
  logic          issue_valid, issue_ready;
  logic [IW-1:0] issue_idx;
  logic [TW-1:0] issue_src1_tag, issue_src2_tag;
  logic [PW-1:0] issue_payload;
  logic          issue_free_valid;
  logic [IW:0]   issue_free;
  logic [IW:0]   occupancy;

  typedef struct {
    logic [IW-1:0] idx;
    logic [TW-1:0] t1;
    logic [TW-1:0] t2;
    logic [PW-1:0] pl;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rs_entry_select dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid_0(disp_valid_0), .disp_valid_1(disp_valid_1),
    .disp_idx_0(disp_idx_0), .disp_idx_1(disp_idx_1),
    .disp_src1_tag_0(disp_src1_tag_0), .disp_src2_tag_0(disp_src2_tag_0),
    .disp_src1_tag_1(disp_src1_tag_1), .disp_src2_tag_1(disp_src2_tag_1),
    .disp_src1_rdy_0(disp_src1_rdy_0), .disp_src2_rdy_0(disp_src2_rdy_0),
    .disp_src1_rdy_1(disp_src1_rdy_1), .disp_src2_rdy_1(disp_src2_rdy_1),
    .disp_payload_0(disp_payload_0), .disp_payload_1(disp_payload_1),
    .cdb_valid_0(cdb_valid_0), .cdb_valid_1(cdb_valid_1),
    .cdb_tag_0(cdb_tag_0), .cdb_tag_1(cdb_tag_1),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_idx(issue_idx),
    .issue_src1_tag(issue_src1_tag), .issue_src2_tag(issue_src2_tag),
    .issue_payload(issue_payload),
    .issue_free_valid(issue_free_valid), .issue_free(issue_free),
    .occupancy(occupancy)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && issue_valid === 1'b1 && issue_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_issue: got idx %0d want none", issue_idx);
      end else begin
        e = exp_q.pop_front();
        chk("sb_idx", 64'(issue_idx), 64'(e.idx));
        chk("sb_free", 64'(issue_free), 64'({1'b0, e.idx}));
        chk("sb_free_v", 64'(issue_free_valid), 64'd1);
        chk("sb_t1", 64'(issue_src1_tag), 64'(e.t1));
        chk("sb_t2", 64'(issue_src2_tag), 64'(e.t2));
        chk("sb_pl", issue_payload, e.pl);
      end
    end
  end

  task automatic clr();
    disp_valid_0 = 1'b0;
    disp_valid_1 = 1'b0;
    cdb_valid_0  = 1'b0;
    cdb_valid_1  = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic d0(input int idx, input int t1, input bit r1,
                    input int t2, input bit r2, input logic [PW-1:0] pl);
    disp_valid_0    = 1'b1;
    disp_idx_0      = IW'(idx);
    disp_src1_tag_0 = TW'(t1);
    disp_src1_rdy_0 = r1;
    disp_src2_tag_0 = TW'(t2);
    disp_src2_rdy_0 = r2;
    disp_payload_0  = pl;
  endtask

  task automatic d1(input int idx, input int t1, input bit r1,
                    input int t2, input bit r2, input logic [PW-1:0] pl);
    disp_valid_1    = 1'b1;
    disp_idx_1      = IW'(idx);
    disp_src1_tag_1 = TW'(t1);
    disp_src1_rdy_1 = r1;
    disp_src2_tag_1 = TW'(t2);
    disp_src2_rdy_1 = r2;
    disp_payload_1  = pl;
  endtask

  task automatic push(input int idx, input int t1, input int t2,
                      input logic [PW-1:0] pl);
    exp_t e;
    e.idx = IW'(idx);
    e.t1  = TW'(t1);
    e.t2  = TW'(t2);
    e.pl  = pl;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    issue_ready = 1'b1;
    clr();
    disp_idx_0 = '0; disp_idx_1 = '0;
    disp_src1_tag_0 = '0; disp_src2_tag_0 = '0;
    disp_src1_tag_1 = '0; disp_src2_tag_1 = '0;
    disp_src1_rdy_0 = 1'b0; disp_src2_rdy_0 = 1'b0;
    disp_src1_rdy_1 = 1'b0; disp_src2_rdy_1 = 1'b0;
    disp_payload_0 = '0; disp_payload_1 = '0;
    cdb_tag_0 = '0; cdb_tag_1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_iv", 64'(issue_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);

    // basic dispatch, issue one cycle later
    d0(3, 1, 1, 2, 1, 64'h3333_0000_0000_0003);
    push(3, 1, 2, 64'h3333_0000_0000_0003);
    step();
    @(negedge clk);
    chk("t1_iv", 64'(issue_valid), 64'd1);
    chk("t1_idx", 64'(issue_idx), 64'd3);
    chk("t1_free", 64'(issue_free), 64'b0011);
    chk("t1_occ", 64'(occupancy), 64'd1);
    step();
    @(negedge clk);
    chk("t1_occ0", 64'(occupancy), 64'd0);
    chk("t1_iv0", 64'(issue_valid), 64'd0);

    // younger ready entry issues before older waiting one
    d0(5, 12, 0, 13, 1, 64'h5555_0000_0000_0005);
    step();
    d0(2, 20, 1, 21, 1, 64'h2222_0000_0000_0002);
    push(2, 20, 21, 64'h2222_0000_0000_0002);
    push(5, 12, 13, 64'h5555_0000_0000_0005);
    step();
    cdb_valid_0 = 1'b1;
    cdb_tag_0   = 6'd12;
    @(negedge clk);
    chk("t2_first", 64'(issue_idx), 64'd2);
    step();
    @(negedge clk);
    chk("t2_second", 64'(issue_idx), 64'd5);
    step();

    // dual dispatch: port 0 older
    d0(6, 3, 1, 4, 1, 64'h6666_0000_0000_0006);
    d1(1, 5, 1, 6, 1, 64'h1111_0000_0000_0001);
    push(6, 3, 4, 64'h6666_0000_0000_0006);
    push(1, 5, 6, 64'h1111_0000_0000_0001);
    step();
    @(negedge clk);
    chk("t3_occ2", 64'(occupancy), 64'd2);
    chk("t3_idx6", 64'(issue_idx), 64'd6);
    step();
    @(negedge clk);
    chk("t3_occ1", 64'(occupancy), 64'd1);
    chk("t3_idx1", 64'(issue_idx), 64'd1);
    step();
    @(negedge clk);
    chk("t3_occ0", 64'(occupancy), 64'd0);

    // same-cycle CDB bypass on dispatch
    d0(7, 30, 1, 40, 0, 64'h7777_0000_0000_0007);
    cdb_valid_1 = 1'b1;
    cdb_tag_1   = 6'd40;
    push(7, 30, 40, 64'h7777_0000_0000_0007);
    step();
    @(negedge clk);
    chk("t4_iv", 64'(issue_valid), 64'd1);
    chk("t4_idx", 64'(issue_idx), 64'd7);
    step();

    // both CDB ports wake both sources of one entry
    d0(2, 50, 0, 51, 0, 64'h2222_0000_0000_0a02);
    step();
    @(negedge clk);
    chk("t7_notrdy", 64'(issue_valid), 64'd0);
    cdb_valid_0 = 1'b1; cdb_tag_0 = 6'd50;
    cdb_valid_1 = 1'b1; cdb_tag_1 = 6'd51;
    push(2, 50, 51, 64'h2222_0000_0000_0a02);
    step();
    @(negedge clk);
    chk("t7_iv", 64'(issue_valid), 64'd1);
    step();

    // older entry woken late still wins
    issue_ready = 1'b0;
    d0(1, 60, 0, 61, 1, 64'h1111_0000_0000_0b01);
    step();
    d0(2, 62, 1, 63, 1, 64'h2222_0000_0000_0b02);
    step();
    cdb_valid_0 = 1'b1; cdb_tag_0 = 6'd60;
    @(negedge clk);
    chk("t8_young", 64'(issue_idx), 64'd2);
    step();
    issue_ready = 1'b1;
    push(1, 60, 61, 64'h1111_0000_0000_0b01);
    push(2, 62, 63, 64'h2222_0000_0000_0b02);
    @(negedge clk);
    chk("t8_old", 64'(issue_idx), 64'd1);
    step();
    @(negedge clk);
    chk("t8_next", 64'(issue_idx), 64'd2);
    step();

    // stall with issue_ready low
    issue_ready = 1'b0;
    d0(4, 7, 1, 8, 1, 64'h4444_0000_0000_0004);
    push(4, 7, 8, 64'h4444_0000_0000_0004);
    step();
    repeat (3) begin
      @(negedge clk);
      chk("t5_hold_iv", 64'(issue_valid), 64'd1);
      chk("t5_hold_free", 64'(issue_free_valid), 64'd0);
      step();
    end
    issue_ready = 1'b1;
    @(negedge clk);
    chk("t5_pulse", 64'(issue_free_valid), 64'd1);
    step();
    @(negedge clk);
    chk("t5_after", 64'(issue_free_valid), 64'd0);

    // fill, then flush with dispatch and CDB active
    issue_ready = 1'b0;
    for (int k = 0; k < 8; k += 2) begin
      d0(k, 9, 1, 10, 1, 64'(k));
      d1(k + 1, 9, 1, 10, 1, 64'(k + 1));
      step();
    end
    @(negedge clk);
    chk("t6_full", 64'(occupancy), 64'd8);
    flush = 1'b1;
    cdb_valid_0 = 1'b1; cdb_tag_0 = 6'd5;
    d0(0, 11, 1, 12, 1, 64'hdead);
    step();
    @(negedge clk);
    chk("t6_fl_iv", 64'(issue_valid), 64'd0);
    chk("t6_fl_occ", 64'(occupancy), 64'd0);
    issue_ready = 1'b1;
    d0(0, 14, 1, 15, 1, 64'h0f0f_0000_0000_0000);
    push(0, 14, 15, 64'h0f0f_0000_0000_0000);
    step();
    @(negedge clk);
    chk("t6_re_idx", 64'(issue_idx), 64'd0);
    chk("t6_re_occ", 64'(occupancy), 64'd1);
    step();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
